// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises word loads/stores from MEM and word fetches from IF onto a
// byte-wide synchronous RAM bus, returning a one-cycle done pulse and the assembled word.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_req_i,
   input  logic        mem_w_req_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_w_data_i,
   input  logic [3:0]  mem_buffer_pointer_i,
   output logic        mem_done_o,
   output logic [31:0] mem_r_data_o,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_done_o,
   output logic [31:0] if_data_o,
   output logic [31:0] ram_a_o,
   output logic        ram_wr_o,
   output logic [7:0]  ram_dout_o,
   input  logic [7:0]  ram_din_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [2:0]  n_q, n_d;
   logic [31:0] a_q, a_d;
   logic [31:0] d_q, d_d;
   logic        src_if_q, src_if_d;
   logic        mem_done_q, mem_done_d;
   logic        if_done_q, if_done_d;
   logic [31:0] mem_r_data_q, mem_r_data_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] ram_a_q, ram_a_d;
   logic        ram_wr_q, ram_wr_d;
   logic [7:0]  ram_dout_q, ram_dout_d;

   logic [2:0]  k_next;
   logic [2:0]  req_n;
   logic        if_abort;

   assign req_n    = (mem_buffer_pointer_i == 4'd0) ? 3'd4
                                                    : 3'd4 - {1'b0, mem_buffer_pointer_i[1:0]};
   assign k_next   = k_q + 3'd1;
   assign if_abort = src_if_q && (!if_req_i || (if_addr_i != a_q));

   // Outputs are computed one cycle ahead so the RAM bus and done pulses come straight off flops.
   // D doubles as a shift register: stores shift bytes out of [15:8], loads shift bytes in at [31:24].
   // NOTE: every always_comb target gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      n_d          = n_q;
      a_d          = a_q;
      d_d          = d_q;
      src_if_d     = src_if_q;
      mem_done_d   = 1'b0;
      if_done_d    = 1'b0;
      mem_r_data_d = mem_r_data_q;
      if_data_d    = if_data_q;
      ram_a_d      = 32'd0;
      ram_wr_d     = 1'b0;
      ram_dout_d   = 8'd0;

      case (state_q)
         IDLE: begin
            k_d = 3'd0;
            if (mem_w_req_i) begin
               state_d    = WRITE;
               a_d        = mem_addr_i;
               d_d        = mem_w_data_i;
               n_d        = req_n;
               src_if_d   = 1'b0;
               ram_a_d    = mem_addr_i;
               ram_wr_d   = 1'b1;
               ram_dout_d = mem_w_data_i[7:0];
            end else if (mem_r_req_i) begin
               state_d  = READ;
               a_d      = mem_addr_i;
               src_if_d = 1'b0;
               ram_a_d  = mem_addr_i;
            end else if (if_req_i) begin
               state_d  = READ;
               a_d      = if_addr_i;
               src_if_d = 1'b1;
               ram_a_d  = if_addr_i;
            end
         end

         READ: begin
            if (if_abort) begin
               state_d = IDLE;
               k_d     = 3'd0;
            end else if (k_q == 3'd4) begin
               state_d = DONE;
               k_d     = 3'd0;
               if (src_if_q) begin
                  if_done_d = 1'b1;
                  if_data_d = {ram_din_i, d_q[31:8]};
               end else begin
                  mem_done_d   = 1'b1;
                  mem_r_data_d = {ram_din_i, d_q[31:8]};
               end
            end else begin
               k_d = k_next;
               if (k_q != 3'd0) d_d = {ram_din_i, d_q[31:8]};
               if (k_next != 3'd4) ram_a_d = a_q + {29'd0, k_next};
            end
         end

         WRITE: begin
            k_d = k_next;
            if (k_next == n_q) begin
               state_d    = DONE;
               k_d        = 3'd0;
               mem_done_d = 1'b1;
            end else begin
               ram_a_d    = a_q + {29'd0, k_next};
               ram_wr_d   = 1'b1;
               ram_dout_d = d_q[15:8];
               d_d        = {8'd0, d_q[31:8]};
            end
         end

         DONE: begin
            state_d = IDLE;
            k_d     = 3'd0;
         end

         default: begin
            state_d = IDLE;
            k_d     = 3'd0;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         k_q          <= 3'd0;
         mem_done_q   <= 1'b0;
         if_done_q    <= 1'b0;
         mem_r_data_q <= 32'd0;
         if_data_q    <= 32'd0;
         ram_a_q      <= 32'd0;
         ram_wr_q     <= 1'b0;
         ram_dout_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         mem_done_q   <= mem_done_d;
         if_done_q    <= if_done_d;
         mem_r_data_q <= mem_r_data_d;
         if_data_q    <= if_data_d;
         ram_a_q      <= ram_a_d;
         ram_wr_q     <= ram_wr_d;
         ram_dout_q   <= ram_dout_d;
      end
   end

   // NOTE: latched request fields are always loaded in IDLE before use, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q      <= a_d;
      d_q      <= d_d;
      n_q      <= n_d;
      src_if_q <= src_if_d;
   end

   assign mem_done_o   = mem_done_q;
   assign if_done_o    = if_done_q;
   assign mem_r_data_o = mem_r_data_q;
   assign if_data_o    = if_data_q;
   assign ram_a_o      = ram_a_q;
   assign ram_wr_o     = ram_wr_q;
   assign ram_dout_o   = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus for mem_ctrl with a byte-RAM responder and a
// transaction-timeline reference model compared against the DUT every cycle.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_req_i, mem_w_req_i;
   logic [31:0] mem_addr_i, mem_w_data_i;
   logic [3:0]  mem_buffer_pointer_i;
   logic        mem_done_o;
   logic [31:0] mem_r_data_o;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_done_o;
   logic [31:0] if_data_o;
   logic [31:0] ram_a_o;
   logic        ram_wr_o;
   logic [7:0]  ram_dout_o;
   logic [7:0]  ram_din_i = 8'd0;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   logic [7:0] ram [logic [31:0]];

   logic [31:0] exp_ram_a, exp_mem_data, exp_if_data;
   logic        exp_ram_wr, exp_mem_done, exp_if_done;
   logic [7:0]  exp_ram_dout;

   logic [31:0] a_log    [0:23];
   logic        wr_log   [0:23];
   logic [7:0]  dout_log [0:23];

   mem_ctrl dut (
      .clk                  (clk),
      .rst                  (rst),
      .mem_r_req_i          (mem_r_req_i),
      .mem_w_req_i          (mem_w_req_i),
      .mem_addr_i           (mem_addr_i),
      .mem_w_data_i         (mem_w_data_i),
      .mem_buffer_pointer_i (mem_buffer_pointer_i),
      .mem_done_o           (mem_done_o),
      .mem_r_data_o         (mem_r_data_o),
      .if_req_i             (if_req_i),
      .if_addr_i            (if_addr_i),
      .if_done_o            (if_done_o),
      .if_data_o            (if_data_o),
      .ram_a_o              (ram_a_o),
      .ram_wr_o             (ram_wr_o),
      .ram_dout_o           (ram_dout_o),
      .ram_din_i            (ram_din_i)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte RAM: write on the edge ending a write cycle, read data one cycle after its address.
   always @(posedge clk) begin
      if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
      ram_din_i <= rd(ram_a_o);
   end

   // ---------------- reference model: one transaction at a time ----------------
   task automatic m_zero_bus();
      exp_ram_a    = 32'd0;
      exp_ram_wr   = 1'b0;
      exp_ram_dout = 8'd0;
      exp_mem_done = 1'b0;
      exp_if_done  = 1'b0;
   endtask

   task automatic m_reset();
      m_zero_bus();
      exp_mem_data = 32'd0;
      exp_if_data  = 32'd0;
   endtask

   // Ends the current cycle; hit reports that reset was sampled on that edge.
   task automatic m_edge(output bit hit);
      @(posedge clk);
      hit = rst;
      if (hit) m_reset();
   endtask

   task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input int n);
      bit hit;
      for (int k = 0; k < n; k++) begin
         exp_ram_a    = addr + 32'(k);
         exp_ram_wr   = 1'b1;
         exp_ram_dout = data[8*k +: 8];
         m_edge(hit);
         if (hit) return;
      end
      m_zero_bus();
      exp_mem_done = 1'b1;
      m_edge(hit);
      if (hit) return;
      exp_mem_done = 1'b0;
   endtask

   task automatic m_read(input logic [31:0] addr, input bit from_if);
      bit hit;
      logic [31:0] word;
      for (int k = 0; k < 4; k++) word[8*k +: 8] = rd(addr + 32'(k));
      for (int c = 0; c < 5; c++) begin
         m_zero_bus();
         if (c < 4) exp_ram_a = addr + 32'(c);
         m_edge(hit);
         if (hit) return;
         if (from_if && (!if_req_i || if_addr_i != addr)) begin
            m_zero_bus();
            return;
         end
      end
      m_zero_bus();
      if (from_if) begin
         exp_if_done = 1'b1;
         exp_if_data = word;
      end else begin
         exp_mem_done = 1'b1;
         exp_mem_data = word;
      end
      m_edge(hit);
      if (hit) return;
      exp_if_done  = 1'b0;
      exp_mem_done = 1'b0;
   endtask

   initial begin : model
      bit hit;
      int n;
      m_reset();
      forever begin
         m_edge(hit);
         if (!hit) begin
            if (mem_w_req_i) begin
               n = (mem_buffer_pointer_i == 4'd0) ? 4 : 4 - int'(mem_buffer_pointer_i[1:0]);
               m_write(mem_addr_i, mem_w_data_i, n);
            end else if (mem_r_req_i) begin
               m_read(mem_addr_i, 1'b0);
            end else if (if_req_i) begin
               m_read(if_addr_i, 1'b1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ram_bus", {ram_a_o, ram_wr_o, ram_dout_o}, {exp_ram_a, exp_ram_wr, exp_ram_dout});
         check("done", {mem_done_o, if_done_o}, {exp_mem_done, exp_if_done});
         check("mem_r_data", mem_r_data_o, exp_mem_data);
         check("if_data", if_data_o, exp_if_data);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_done(input bit want_if, output int lat);
      lat = -1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         a_log[i]    = ram_a_o;
         wr_log[i]   = ram_wr_o;
         dout_log[i] = ram_dout_o;
         if ((want_if ? if_done_o : mem_done_o) == 1'b1) begin
            lat = i;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] ptr, output int lat);
      mem_addr_i           = addr;
      mem_w_data_i         = data;
      mem_buffer_pointer_i = ptr;
      mem_w_req_i          = 1'b1;
      wait_done(1'b0, lat);
      mem_w_req_i = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output int lat);
      mem_addr_i  = addr;
      mem_r_req_i = 1'b1;
      wait_done(1'b0, lat);
      mem_r_req_i = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int lat, n_md, t_md, t_id, n_id;
      rst = 1'b1;
      mem_r_req_i = 1'b0; mem_w_req_i = 1'b0; if_req_i = 1'b0;
      mem_addr_i = 32'd0; mem_w_data_i = 32'd0; mem_buffer_pointer_i = 4'd0; if_addr_i = 32'd0;
      ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
      ram[32'h200] = 8'h01; ram[32'h201] = 8'h02; ram[32'h202] = 8'h03; ram[32'h203] = 8'h04;
      ram[32'h313] = 8'h99;
      ram[32'h500] = 8'hEF; ram[32'h501] = 8'hBE; ram[32'h502] = 8'hAD; ram[32'h503] = 8'hDE;
      ram[32'h0]   = 8'hA0; ram[32'h1]   = 8'hA1; ram[32'h2]   = 8'hA2; ram[32'h3]   = 8'hA3;
      ram[32'h40]  = 8'h10; ram[32'h41]  = 8'h20; ram[32'h42]  = 8'h30; ram[32'h43]  = 8'h40;
      for (int i = 0; i < 4; i++) ram[32'h600 + 32'(i)] = 8'hEE;

      @(posedge clk); #1;
      cmp_en = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(negedge clk);
      check("reset_ram_a", ram_a_o, 32'd0);
      check("reset_wr", ram_wr_o, 1'b0);
      check("reset_done", {mem_done_o, if_done_o}, 2'b00);
      check("reset_data", {mem_r_data_o, if_data_o}, 64'd0);
      @(posedge clk); #1;

      // Load word at 0x100
      do_read(32'h100, lat);
      check("load_lat", lat, 6);
      check("load_data", mem_r_data_o, 32'h44332211);
      for (int k = 0; k < 4; k++) check($sformatf("load_addr%0d", k), a_log[k+1], 32'h100 + 32'(k));
      check("load_addr_after", a_log[5], 32'd0);
      check("load_no_write", {wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 4'b0000);

      // Byte, half, word and 3-byte stores
      do_write(32'h200, 32'hAABBCCDD, 4'd3, lat);
      check("sb_lat", lat, 2);
      check("sb_bus", {wr_log[1], dout_log[1], wr_log[2]}, {1'b1, 8'hDD, 1'b0});
      check("sb_ram", {rd(32'h200), rd(32'h201)}, 16'hDD02);
      do_write(32'h200, 32'hAABBCCDD, 4'd2, lat);
      check("sh_lat", lat, 3);
      check("sh_ram", {rd(32'h200), rd(32'h201), rd(32'h202)}, 24'hDDCC03);
      do_write(32'h300, 32'h12345678, 4'd0, lat);
      check("sw_lat", lat, 5);
      check("sw_ram", {rd(32'h303), rd(32'h302), rd(32'h301), rd(32'h300)}, 32'h12345678);
      do_write(32'h310, 32'hCAFEF00D, 4'd1, lat);
      check("s3_lat", lat, 4);
      check("s3_ram", {rd(32'h313), rd(32'h312), rd(32'h311), rd(32'h310)}, 32'h99FEF00D);
      do_read(32'h300, lat);
      check("sw_readback", mem_r_data_o, 32'h12345678);

      // Write wins over a simultaneous read
      mem_r_req_i = 1'b1;
      do_write(32'h320, 32'h0000005A, 4'd3, lat);
      mem_r_req_i = 1'b0;
      check("w_over_r_lat", lat, 2);
      check("w_over_r_ram", rd(32'h320), 8'h5A);

      // MEM beats IF; MEM request held through DONE is not re-served
      mem_addr_i = 32'h100; mem_r_req_i = 1'b1;
      if_addr_i = 32'h500; if_req_i = 1'b1;
      n_md = 0; n_id = 0; t_md = -1; t_id = -1;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (mem_done_o) begin n_md++; t_md = j; end
         if (if_done_o) begin n_id++; t_id = j; end
         @(posedge clk); #1;
         if (j + 1 == 7) mem_r_req_i = 1'b0;
         if (j + 1 == 14) if_req_i = 1'b0;
      end
      check("cont_mem_done_count", n_md, 1);
      check("cont_mem_done_time", t_md, 6);
      check("cont_if_done_count", n_id, 1);
      check("cont_if_done_time", t_id, 13);
      check("cont_if_data", if_data_o, 32'hDEADBEEF);
      check("cont_mem_data", mem_r_data_o, 32'h44332211);

      // IF abort on address change, then fetch of the new address
      if_addr_i = 32'h0; if_req_i = 1'b1;
      n_id = 0; t_id = -1;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (if_done_o) begin n_id++; t_id = j; end
         if (j == 8) check("abort_data_held", if_data_o, 32'hDEADBEEF);
         @(posedge clk); #1;
         if (j + 1 == 3) if_addr_i = 32'h40;
         if (j + 1 == 11) if_req_i = 1'b0;
      end
      check("abort_if_done_count", n_id, 1);
      check("abort_if_done_time", t_id, 10);
      check("abort_if_data", if_data_o, 32'h40302010);

      // Address wrap on a word store and a word load
      do_write(32'hFFFFFFFE, 32'h04030201, 4'd0, lat);
      check("wrap_lat", lat, 5);
      check("wrap_a1", a_log[1], 32'hFFFFFFFE);
      check("wrap_a2", a_log[2], 32'hFFFFFFFF);
      check("wrap_a3", a_log[3], 32'h00000000);
      check("wrap_a4", a_log[4], 32'h00000001);
      check("wrap_ram", {rd(32'h1), rd(32'h0), rd(32'hFFFFFFFF), rd(32'hFFFFFFFE)}, 32'h04030201);
      do_read(32'hFFFFFFFE, lat);
      check("wrap_read", mem_r_data_o, 32'h04030201);

      // Reset in the middle of a word store
      mem_addr_i = 32'h600; mem_w_data_i = 32'h55667788; mem_buffer_pointer_i = 4'd0;
      mem_w_req_i = 1'b1;
      n_md = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (mem_done_o) n_md++;
         if (j == 3) begin
            check("rst_mid_bus", {ram_a_o, ram_wr_o, ram_dout_o}, 41'd0);
            check("rst_mid_data", {mem_r_data_o, if_data_o}, 64'd0);
         end
         @(posedge clk); #1;
         if (j + 1 == 2) rst = 1'b1;
         if (j + 1 == 3) begin rst = 1'b0; mem_w_req_i = 1'b0; end
      end
      check("rst_mid_no_done", n_md, 0);
      check("rst_mid_ram", {rd(32'h603), rd(32'h602), rd(32'h601), rd(32'h600)}, 32'hEEEE7788);
      do_read(32'h600, lat);
      check("post_rst_lat", lat, 6);
      check("post_rst_read", mem_r_data_o, 32'hEEEE7788);

      repeat (3) begin @(posedge clk); #1; end
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side responder for the core's load/store and fetch request interface. It accepts word-oriented read/write requests from the MEM stage and word reads from the IF stage, then sequences them over the byte-wide synchronous RAM bus. It returns a one-cycle done pulse plus the assembled little-endian read data. It sits between the pipeline stages and the external RAM port.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mem_r_req_i  in  1  MEM load request; held until done
- mem_w_req_i  in  1  MEM store request; held until done
- mem_addr_i  in  32  MEM byte address
- mem_w_data_i  in  32  store data, right-aligned
- mem_buffer_pointer_i  in  4  store size code: 0 = 4 bytes, 2 = 2 bytes, 3 = 1 byte, 1 = 3 bytes; count n = (ptr==0) ? 4 : 4-ptr[1:0]
- mem_done_o  out  1  one-cycle completion pulse for MEM
- mem_r_data_o  out  32  assembled load word
- if_req_i  in  1  instruction fetch request; held until done
- if_addr_i  in  32  fetch address
- if_done_o  out  1  one-cycle completion pulse for IF
- if_data_o  out  32  fetched word
- ram_a_o  out  32  RAM byte address
- ram_wr_o  out  1  1 = write ram_dout_o at ram_a_o this cycle
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte, valid the cycle after its address

## Operation
- FSM states: IDLE, READ, WRITE, DONE; byte counter k (0..4), latched address A, latched data D, latched count n, latched source (MEM/IF).
- IDLE arbitration, checked in this order:
  - mem_w_req_i: go to WRITE. Wins if mem_r_req_i is also high.
  - mem_r_req_i: go to READ.
  - if_req_i: go to READ with source IF.
  - Otherwise stay in IDLE.
  - MEM always beats IF.
- Requests arriving while not in IDLE are ignored; requesters hold them.
- READ: always 4 bytes.
  - Drive ram_a_o = A+k, k = 0..3, with ram_wr_o = 0.
  - Byte from A+k lands in bits [8k+7:8k].
- WRITE: drive ram_a_o = A+k, ram_dout_o = D[8k+7:8k], ram_wr_o = 1 for k = 0..n-1.
- A+k is a 32-bit add, modulo 2^32: 0xFFFFFFFF+1 wraps to 0x00000000.
- DONE: exactly one cycle.
  - Pulse mem_done_o or if_done_o according to source.
  - For a MEM read, mem_r_data_o takes the new word on entry to DONE; for an IF read, if_data_o does. Each holds its value until its next completed read.
  - Next state is always IDLE. This cooldown guarantees a request held through the done edge is not re-served.
- IF abort: during an IF READ, if if_req_i = 0 or if_addr_i != A in any cycle, return to IDLE next cycle. No done pulse, and if_data_o is unchanged.
- MEM transactions are never aborted.
- Outside READ/WRITE: ram_a_o = 0, ram_wr_o = 0, ram_dout_o = 0.
- Reset: at any clock edge with rst = 1:
  - state = IDLE, k = 0.
  - All outputs become 0: done pulses, data outputs, ram_a_o, ram_wr_o, ram_dout_o.
  - A write in flight stops; bytes already written remain.

## Timing
- Let T be the IDLE cycle in which a request is accepted. All outputs are registered.
- Read: ram_a_o = A+k in cycle T+1+k, k = 0..3. The byte is captured at the end of cycle T+2+k. Done is high in T+6; data valid in T+6.
- Write of n bytes: ram_wr_o high in cycles T+1 .. T+n. Done is high in T+1+n (1 byte: T+2; 4 bytes: T+5).
- IDLE resumes in T+7 (read) or T+2+n (write). Earliest next acceptance is that cycle.
- Back-to-back MEM reads: 7 cycles per word.
- An IF request pending during a MEM transaction is served after it. Worst-case IF wait = one full MEM transaction + 1 cycle.

## Test plan
- Load: RAM[0x100..0x103] = 0x11,0x22,0x33,0x44; mem_r_req_i = 1, addr 0x100 at T -> ram_a_o = 0x100..0x103 in T+1..T+4, mem_done_o = 1 only in T+6, mem_r_data_o = 0x44332211.
- Stores: SB ptr = 3, data 0xAABBCCDD, addr 0x200 -> one write of 0xDD at 0x200, done in T+2. SH ptr = 2 -> 0xDD@0x200, 0xCC@0x201, done in T+3. SW ptr = 0 -> 4 bytes, done in T+5.
- Contention and hold: mem_r_req_i and if_req_i both high at T -> MEM served first. IF then starts in the first IDLE cycle (T+7), if_done_o in T+13. No second MEM transaction while mem_r_req_i stays high through DONE.
- IF abort: if_addr_i changes from 0x0 to 0x40 at T+3 -> no if_done_o for 0x0. The fetch of 0x40 completes with if_data_o equal to RAM[0x40..0x43].
- Wrap: SW at 0xFFFFFFFE -> writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset: rst = 1 at T+2 of a SW -> ram_wr_o = 0 and all outputs 0 from T+3, no mem_done_o. A new request after rst deasserts is served normally.
